// File: rtl/text_ctrl_pkg.sv
// Shared FSM states, cursor operations and character codes for the text write controller.
package text_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROWCLR = 2'd1,
        CLEAR  = 2'd2
    } text_state_e;

    typedef enum logic [2:0] {
        CUR_NOP  = 3'd0,
        CUR_ADV  = 3'd1,
        CUR_NL   = 3'd2,
        CUR_BS   = 3'd3,
        CUR_ZERO = 3'd4
    } cur_op_e;

    localparam logic [7:0] CHAR_BS       = 8'h08;
    localparam logic [7:0] CHAR_LF       = 8'h0A;
    localparam logic [7:0] CHAR_CR       = 8'h0D;
    localparam logic [7:0] CHAR_FILTER   = 8'h7E;
    localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHAR_PRINT_HI = 8'h7D;

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= CHAR_PRINT_LO) && (ch <= CHAR_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor row/column counter: advance, newline, backspace and zero operations.
// Exposes the next position plus row-advance / backward-move events to the controller.
module text_cursor
    import text_ctrl_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 32,
    localparam int ROW_W = $clog2(ROWS),
    localparam int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cur_op_e          op,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] nxt_row,
    output logic [COL_W-1:0] nxt_col,
    output logic             row_adv,
    output logic             moved_back
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_inc_s;

    assign row_inc_s = (row_r == ROW_LAST) ? ROW_W'(0) : row_r + ROW_W'(1);
    assign row       = row_r;
    assign col       = col_r;

    // Next cursor position and events for the requested operation
    always_comb begin
        nxt_row    = row_r;
        nxt_col    = col_r;
        row_adv    = 1'b0;
        moved_back = 1'b0;
        case (op)
            CUR_ADV: begin
                if (col_r == COL_LAST) begin
                    nxt_col = COL_W'(0);
                    nxt_row = row_inc_s;
                    row_adv = 1'b1;
                end else begin
                    nxt_col = col_r + COL_W'(1);
                end
            end
            CUR_NL: begin
                nxt_col = COL_W'(0);
                nxt_row = row_inc_s;
                row_adv = 1'b1;
            end
            CUR_BS: begin
                if (col_r != COL_W'(0)) begin
                    nxt_col    = col_r - COL_W'(1);
                    moved_back = 1'b1;
                end else if (row_r != ROW_W'(0)) begin
                    nxt_row    = row_r - ROW_W'(1);
                    nxt_col    = COL_LAST;
                    moved_back = 1'b1;
                end else begin
                    moved_back = 1'b0;
                end
            end
            CUR_ZERO: begin
                nxt_row = ROW_W'(0);
                nxt_col = COL_W'(0);
            end
            default: begin
                nxt_row = row_r;
                nxt_col = col_r;
            end
        endcase
    end

    // Cursor position register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_r <= ROW_W'(0);
            col_r <= COL_W'(0);
        end else begin
            row_r <= nxt_row;
            col_r <= nxt_col;
        end
    end

endmodule

// File: rtl/text_write_ctrl.sv
// Write-side controller for the character display RAM: character stream, cursor, fills.
// Optional macro TEXT_ROW_CLEAR_EN: clear the newly entered row on every row advance.
module text_write_ctrl
    import text_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ROWS       = 4,
    parameter int                    COLS       = 32,
    parameter logic [DATA_WIDTH-1:0] FILL_CHAR  = 8'h20,
    localparam int ROW_W = $clog2(ROWS),
    localparam int COL_W = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ROW_W-1:0]      ram_row,
    output logic [COL_W-1:0]      ram_col,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ROW_W-1:0]      cur_row,
    output logic [COL_W-1:0]      cur_col
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    text_state_e           state_r, state_nxt_s;
    logic                  clr_pend_r, clr_pend_nxt_s, clr_go_s;
    logic [ROW_W-1:0]      fill_row_r, fill_row_nxt_s;
    logic [COL_W-1:0]      fill_col_r, fill_col_nxt_s;
    logic                  fill_last_s;
    logic                  we_r, we_nxt_s;
    logic [ROW_W-1:0]      wr_row_r, wr_row_nxt_s;
    logic [COL_W-1:0]      wr_col_r, wr_col_nxt_s;
    logic [DATA_WIDTH-1:0] wr_din_r, wr_din_nxt_s;
    logic                  in_ready_r, in_ready_nxt_s;
    logic                  busy_r, busy_nxt_s;
    cur_op_e               cur_op_s;
    logic [ROW_W-1:0]      cur_row_s, nxt_row_s;
    logic [COL_W-1:0]      cur_col_s, nxt_col_s;
    logic                  row_adv_s, moved_back_s;

    text_cursor #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_cursor (
        .clk        (clk),
        .reset      (reset),
        .op         (cur_op_s),
        .row        (cur_row_s),
        .col        (cur_col_s),
        .nxt_row    (nxt_row_s),
        .nxt_col    (nxt_col_s),
        .row_adv    (row_adv_s),
        .moved_back (moved_back_s)
    );

    assign clr_go_s       = clr_req || clr_pend_r;
    assign fill_last_s    = (fill_row_r == ROW_LAST) && (fill_col_r == COL_LAST);
    assign in_ready_nxt_s = (state_nxt_s == IDLE) && !clr_pend_nxt_s;
    assign busy_nxt_s     = (state_nxt_s != IDLE) || clr_pend_nxt_s;

    // Character decode; a pending clear wins and drops a character offered in the same cycle
    always_comb begin
        cur_op_s = CUR_NOP;
        if ((state_r == IDLE) && !clr_go_s && in_valid && in_ready_r) begin
            if (is_printable(in_data)) begin
                cur_op_s = CUR_ADV;
            end else if ((in_data == CHAR_CR) || (in_data == CHAR_LF)) begin
                cur_op_s = CUR_NL;
            end else if (in_data == CHAR_BS) begin
                cur_op_s = CUR_BS;
            end else begin
                cur_op_s = CUR_NOP;
            end
        end else if ((state_r == CLEAR) && fill_last_s) begin
            cur_op_s = CUR_ZERO;
        end else begin
            cur_op_s = CUR_NOP;
        end
    end

    // Next state, fill address and RAM write port
    always_comb begin
        state_nxt_s    = state_r;
        clr_pend_nxt_s = clr_pend_r || clr_req;
        fill_row_nxt_s = fill_row_r;
        fill_col_nxt_s = fill_col_r;
        we_nxt_s       = 1'b0;
        wr_row_nxt_s   = wr_row_r;
        wr_col_nxt_s   = wr_col_r;
        wr_din_nxt_s   = wr_din_r;
        case (state_r)
            IDLE: begin
                if (clr_go_s) begin
                    state_nxt_s = CLEAR;
`ifdef TEXT_ROW_CLEAR_EN
                end else if (row_adv_s) begin
                    state_nxt_s = ROWCLR;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
                if (clr_go_s || row_adv_s) begin
                    fill_row_nxt_s = ROW_W'(0);
                    fill_col_nxt_s = COL_W'(0);
                end else begin
                    fill_row_nxt_s = fill_row_r;
                    fill_col_nxt_s = fill_col_r;
                end
                if (cur_op_s == CUR_ADV) begin
                    we_nxt_s     = 1'b1;
                    wr_row_nxt_s = cur_row_s;
                    wr_col_nxt_s = cur_col_s;
                    wr_din_nxt_s = in_data;
                end else if ((cur_op_s == CUR_BS) && moved_back_s) begin
                    we_nxt_s     = 1'b1;
                    wr_row_nxt_s = nxt_row_s;
                    wr_col_nxt_s = nxt_col_s;
                    wr_din_nxt_s = FILL_CHAR;
                end else begin
                    we_nxt_s = 1'b0;
                end
            end
`ifdef TEXT_ROW_CLEAR_EN
            ROWCLR: begin
                we_nxt_s     = 1'b1;
                wr_row_nxt_s = cur_row_s;
                wr_col_nxt_s = fill_col_r;
                wr_din_nxt_s = FILL_CHAR;
                if (fill_col_r == COL_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    fill_col_nxt_s = fill_col_r + COL_W'(1);
                end
            end
`endif
            CLEAR: begin
                we_nxt_s     = 1'b1;
                wr_row_nxt_s = fill_row_r;
                wr_col_nxt_s = fill_col_r;
                wr_din_nxt_s = FILL_CHAR;
                if (fill_last_s) begin
                    state_nxt_s    = IDLE;
                    clr_pend_nxt_s = 1'b0;
                end else if (fill_col_r == COL_LAST) begin
                    fill_col_nxt_s = COL_W'(0);
                    fill_row_nxt_s = fill_row_r + ROW_W'(1);
                end else begin
                    fill_col_nxt_s = fill_col_r + COL_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, fill counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            clr_pend_r <= 1'b0;
            fill_row_r <= ROW_W'(0);
            fill_col_r <= COL_W'(0);
            we_r       <= 1'b0;
            wr_row_r   <= ROW_W'(0);
            wr_col_r   <= COL_W'(0);
            wr_din_r   <= DATA_WIDTH'(0);
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            clr_pend_r <= clr_pend_nxt_s;
            fill_row_r <= fill_row_nxt_s;
            fill_col_r <= fill_col_nxt_s;
            we_r       <= we_nxt_s;
            wr_row_r   <= wr_row_nxt_s;
            wr_col_r   <= wr_col_nxt_s;
            wr_din_r   <= wr_din_nxt_s;
            in_ready_r <= in_ready_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign ram_we   = we_r;
    assign ram_row  = wr_row_r;
    assign ram_col  = wr_col_r;
    assign ram_din  = wr_din_r;
    assign cur_row  = cur_row_s;
    assign cur_col  = cur_col_s;

endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Write-side controller for the 4×32 character display RAM. It accepts a character stream over a valid/ready handshake and tracks a text cursor. It interprets control characters and drives the RAM write port (`we`, `w_row`, `w_col`, `din`). It also runs multi-cycle fill sequences for full-screen clear and for clearing a row on wrap. The display scanner keeps sole ownership of the RAM read port; this block never touches it.

## Interface
- `DATA_WIDTH`, 8, character width
- `ROWS`, 4, text rows; must equal RAM `ROWS`
- `COLS`, 32, text columns; must equal RAM `COLS`
- `FILL_CHAR`, 8'h20, character written by clear, backspace and row-clear
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data` valid
- `in_data`  in  DATA_WIDTH  incoming character
- `in_ready`  out  1  block accepts `in_data` this cycle
- `clr_req`  in  1  one-cycle pulse requesting a full-screen clear
- `busy`  out  1  a fill sequence is running or pending
- `ram_we`  out  1  RAM write enable
- `ram_row`  out  $clog2(ROWS)  RAM write row
- `ram_col`  out  $clog2(COLS)  RAM write column
- `ram_din`  out  DATA_WIDTH  RAM write data
- `cur_row`  out  $clog2(ROWS)  cursor row, for display highlight
- `cur_col`  out  $clog2(COLS)  cursor column

## Operation
- States: IDLE, ROWCLR, CLEAR. All outputs are registered.
- `in_ready` = (state==IDLE) && !clr_pend. A transfer happens when `in_valid && in_ready`.
- Accepted character classes:
  - Printable 8'h20–8'h7D:
    - Write the character at the cursor, then advance `cur_col`.
    - At `cur_col`==COLS-1: set col to 0 and advance the row (see wrap).
  - 8'h0D or 8'h0A: set col to 0 and advance the row. No write.
  - 8'h08 (backspace):
    - If col>0: col-1, and write FILL_CHAR there.
    - If col==0 and row>0: move to (row-1, COLS-1) and write FILL_CHAR.
    - At (0,0): no-op.
  - 8'h7E and every other code: consumed, no write, cursor unchanged. 8'h7E must never be driven on `ram_din`.
- Row advance:
  - Row increments modulo ROWS, so row ROWS-1 wraps to 0.
  - The new row is always cleared: go to ROWCLR, write FILL_CHAR to cols 0..COLS-1 of the new row, then return to IDLE.
- `clr_req`:
  - Sets `clr_pend`. In IDLE, `clr_pend` has priority over `in_valid` in the same cycle.
  - CLEAR writes FILL_CHAR to every cell, row-major, (0,0) through (ROWS-1,COLS-1). It then resets the cursor to (0,0) and clears `clr_pend`.
  - A `clr_req` arriving during ROWCLR or CLEAR is held pending. Multiple pulses collapse into one clear.
- `busy` = (state!=IDLE) || clr_pend.

## Timing
- Reset (asynchronous, immediate): state IDLE; `ram_we`=0; `ram_row`, `ram_col`, `ram_din`=0; cursor (0,0); `clr_pend`=0; `busy`=0. `in_ready` goes to 1 on the first edge after release.
- Character write: `ram_we`=1 for exactly one cycle, on the cycle after the accepting edge. The cursor updates on the accepting edge.
- Back-to-back printable characters are accepted every cycle, one write per cycle.
- ROWCLR: entered the cycle after the accepting edge. COLS consecutive `ram_we` cycles; `in_ready`=0 throughout; IDLE on the following cycle.
- A printable character at col COLS-1 produces its own write, then the COLS row-clear writes, with no gap.
- CLEAR: ROWS*COLS consecutive `ram_we` cycles, starting the cycle after `clr_req` is seen in IDLE. Cursor reads (0,0) when `busy` falls.
- Reset asserted mid-sequence aborts it. The RAM keeps whatever was partially written.

## Configuration
- `TEXT_ROW_CLEAR_EN` defined: row advance enters ROWCLR as described above.
- Not defined:
  - Row advance moves the cursor only; the ROWCLR state is not built.
  - Old row content remains and is overwritten character by character.
  - `in_ready` stays high across newlines.

## Structure
- Package `text_ctrl_pkg`: state enum; character constants CHAR_BS=8'h08, CHAR_LF=8'h0A, CHAR_CR=8'h0D, CHAR_FILTER=8'h7E, CHAR_PRINT_LO=8'h20, CHAR_PRINT_HI=8'h7D.
- Sub-module `text_cursor`: row/col counter with advance, backspace, newline and zero operations. It reports wrap and row-advance events.
- Fill sequencing (ROWCLR, CLEAR) stays in the top-level FSM and reuses a shared fill-address counter.

## Test plan
- Reset release, send "AB" back-to-back → writes (0,0)=8'h41, (0,1)=8'h42 on consecutive cycles; cursor (0,2).
- Send 32 × 8'h41 from (0,0) → 32 writes on row 0; then 32 FILL_CHAR writes on row 1; `in_ready`=0 for 32 cycles; cursor (1,0).
- Cursor (3,5), send 8'h0D → no data write; row 0 cleared with 8'h20; cursor (0,0). Without `TEXT_ROW_CLEAR_EN`: no writes at all.
- Cursor (2,0), send 8'h08 → write 8'h20 at (1,31); cursor (1,31). At (0,0), 8'h08 → no write, cursor unchanged.
- Send 8'h7E and 8'h01 → both accepted; no `ram_we`; cursor unchanged.
- `clr_req` pulsed twice during a ROWCLR → exactly one CLEAR of 128 writes after ROWCLR ends; `busy` falls with cursor (0,0). `reset` low mid-CLEAR → `ram_we`=0 immediately.
